shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_multiplier.sv | 57 +++++
 tb/tb_shift_add_multiplier.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: 8x8 unsigned sequential multiplier using an external 8-bit adder
module shift_add_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [7:0]  add_a,
  output logic [7:0]  add_b,
  output logic        add_cin,
  input  logic [7:0]  add_sum,
  input  logic        add_cout
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state, state_nxt;
  logic [7:0]  a, q, m;
  logic [2:0]  cnt;
  logic [15:0] product_reg;
  logic [15:0] shifted;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (start ? CALC : IDLE) :
                (state == CALC) ? ((cnt == 3'd7) ? DONE : CALC) : IDLE;
  end
  assign busy    = (state == CALC);
  assign done    = (state == DONE);
  assign product = product_reg;
  assign add_a   = a;
  assign add_b   = q[0] ? m : 8'h00;
  assign add_cin = 1'b0;
  assign shifted = {add_cout, add_sum, q[7:1]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a           <= 8'h00;
      q           <= 8'h00;
      m           <= 8'h00;
      cnt         <= 3'd0;
      product_reg <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        a   <= 8'h00;
        q   <= multiplier;
        m   <= multiplicand;
        cnt <= 3'd0;
      end else if (state == CALC) begin
        {a, q} <= shifted;
        cnt    <= cnt + 3'd1;
        if (cnt == 3'd7) product_reg <= shifted;
      end
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: scoreboard-based self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_sum;
  logic        add_cout;
  int          checks = 0;
  int          errors = 0;
  bit          saw_cout;
  logic [15:0] sb[$];
  shift_add_multiplier dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .busy(busy),
    .done(done),
    .product(product),
    .add_a(add_a),
    .add_b(add_b),
    .add_cin(add_cin),
    .add_sum(add_sum),
    .add_cout(add_cout)
  );
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_op(input logic [7:0] mm, input logic [7:0] qq, input bit detail, input int poke);
    logic [15:0] prev;
    logic [15:0] exp;
    prev = product;
    multiplicand = mm;
    multiplier = qq;
    start = 1'b1;
    sb.push_back(16'(mm) * 16'(qq));
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (add_cout) saw_cout = 1'b1;
      if (detail) begin
        chk("busy_calc", 16'(busy), 16'd1);
        chk("done_calc", 16'(done), 16'd0);
        chk("product_hold_calc", product, prev);
      end
      if (i == poke) begin
        start = 1'b1;
        multiplicand = ~mm;
        multiplier = qq ^ 8'h5A;
      end else if (i == poke + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("done_pulse", 16'(done), 16'd1);
    chk("busy_done", 16'(busy), 16'd0);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 16'd0, 16'd1);
    end else begin
      exp = sb.pop_front();
      chk("product", product, exp);
    end
    @(negedge clk);
    chk("done_one_cycle", 16'(done), 16'd0);
    chk("busy_after", 16'(busy), 16'd0);
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = 8'h00;
    multiplier = 8'h00;
    #3;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_product", product, 16'h0000);
    chk("rst_add_a", 16'(add_a), 16'd0);
    chk("rst_add_b", 16'(add_b), 16'd0);
    chk("rst_add_cin", 16'(add_cin), 16'd0);
    start = 1'b1;
    multiplicand = 8'hFF;
    multiplier = 8'hFF;
    repeat (2) @(negedge clk);
    chk("rst_hold_busy", 16'(busy), 16'd0);
    start = 1'b0;
    rst_n = 1'b1;
    do_op(8'h0D, 8'h0B, 1'b1, -1);
    repeat (3) @(negedge clk);
    chk("idle_hold_product", product, 16'h008F);
    saw_cout = 1'b0;
    do_op(8'hFF, 8'hFF, 1'b1, -1);
    chk("saw_cout", 16'(saw_cout), 16'd1);
    do_op(8'h00, 8'hA5, 1'b1, -1);
    do_op(8'h80, 8'h02, 1'b1, -1);
    do_op(8'h37, 8'h19, 1'b1, 3);
    repeat (3) begin
      @(negedge clk);
      chk("no_queued_start", 16'(busy), 16'd0);
      chk("no_extra_done", 16'(done), 16'd0);
    end
    multiplicand = 8'hC3;
    multiplier = 8'h5A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", 16'(busy), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_product", product, 16'h0000);
    chk("abort_done", 16'(done), 16'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 16'(done), 16'd0);
    end
    rst_n = 1'b1;
    do_op(8'hC3, 8'h5A, 1'b1, -1);
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op(8'($urandom), 8'($urandom), 1'b0, -1);
    end
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
